// File: rtl/seg_scan_rx.sv
// Bus monitor for the multiplexed six-digit 7-segment display: rebuilds the
// scanned digits, decodes them to BCD/MM:SS and flags protocol errors.
module seg_scan_rx #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  input  logic        i_err_clr,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic [5:0]  o_blank,
  output logic [5:0]  o_min,
  output logic [5:0]  o_sec,
  output logic        o_time_vld,
  output logic        o_frame_vld,
  output logic        o_err_seg,
  output logic        o_err_enb
);

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYC);

  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

  // Returns {blank, bad, bcd}.
  function automatic logic [5:0] seg_dec(input logic [6:0] s);
    case (s)
      7'h7E:   seg_dec = {2'b00, 4'd0};
      7'h30:   seg_dec = {2'b00, 4'd1};
      7'h6D:   seg_dec = {2'b00, 4'd2};
      7'h79:   seg_dec = {2'b00, 4'd3};
      7'h33:   seg_dec = {2'b00, 4'd4};
      7'h5B:   seg_dec = {2'b00, 4'd5};
      7'h5F:   seg_dec = {2'b00, 4'd6};
      7'h70:   seg_dec = {2'b00, 4'd7};
      7'h7F:   seg_dec = {2'b00, 4'd8};
      7'h73:   seg_dec = {2'b00, 4'd9};
      7'h00:   seg_dec = {2'b10, 4'hF};
      default: seg_dec = {2'b01, 4'hE};
    endcase
  endfunction

  logic [6:0] seg_s1_q, seg_s2_q;
  logic       dp_s1_q, dp_s2_q;
  logic [5:0] enb_s1_q, enb_s2_q;

  // Enables come out of reset inactive so the idle bus is not seen as a
  // multi-enable word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      dp_s1_q  <= 1'b0;
      dp_s2_q  <= 1'b0;
      enb_s1_q <= '1;
      enb_s2_q <= '1;
    end else begin
      seg_s1_q <= i_seg;
      seg_s2_q <= seg_s1_q;
      dp_s1_q  <= i_seg_dp;
      dp_s2_q  <= dp_s1_q;
      enb_s1_q <= i_seg_enb;
      enb_s2_q <= enb_s1_q;
    end
  end

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [5:0][3:0] shadow_q, shadow_d;
  logic [5:0]      sdp_q, sdp_d, sblank_q, sblank_d, mask_q, mask_d;
  logic [5:0][3:0] digits_q, digits_d;
  logic [5:0]      dp_q, dp_d, blank_q, blank_d;
  logic [5:0]      min_q, min_d, sec_q, sec_d;
  logic            tv_q, tv_d, frame_q, frame_d;
  logic            err_seg_q, err_seg_d, err_enb_q, err_enb_d;

  logic       word_chg, enb_idle, one_hot;
  logic [5:0] enb_act, dec;
  logic       capture, commit, tv_c;
  logic [7:0] min_full, sec_full;

  // cnt_q counts how many cycles the word in the s2 stage has been stable.
  assign word_chg = {enb_s1_q, seg_s1_q, dp_s1_q} != {enb_s2_q, seg_s2_q, dp_s2_q};
  assign enb_act  = ~enb_s2_q;
  assign enb_idle = (enb_act == 6'd0);
  assign one_hot  = !enb_idle && ((enb_act & (enb_act - 6'd1)) == 6'd0);
  assign dec      = seg_dec(seg_s2_q);

  always_comb begin
    cnt_d     = word_chg ? 8'd1 : (cnt_q == SETTLE_N) ? cnt_q : cnt_q + 8'd1;
    state_d   = state_q;
    capture   = 1'b0;
    commit    = 1'b0;
    shadow_d  = shadow_q;
    sdp_d     = sdp_q;
    sblank_d  = sblank_q;
    mask_d    = mask_q;
    digits_d  = digits_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tv_d      = tv_q;
    frame_d   = 1'b0;
    err_seg_d = err_seg_q & ~i_err_clr;
    err_enb_d = err_enb_q & ~i_err_clr;

    case (state_q)
      S_WAIT:   if (!enb_idle) state_d = S_SETTLE;
      S_SETTLE: begin
        if (enb_idle) state_d = S_WAIT;
        else if (cnt_q == SETTLE_N) begin
          capture = 1'b1;
          state_d = S_HELD;
        end
      end
      // Saturated counter only reads 1 on the cycle the word changed.
      S_HELD:   if (cnt_q == 8'd1) state_d = enb_idle ? S_WAIT : S_SETTLE;
      default:  state_d = S_WAIT;
    endcase

    if (capture) begin
      if (one_hot) begin
        for (int k = 0; k < 6; k++) begin
          if (enb_act[k]) begin
            shadow_d[k] = dec[3:0];
            sdp_d[k]    = dp_s2_q;
            sblank_d[k] = dec[5];
          end
        end
        if (dec[4]) err_seg_d = 1'b1;
        if (enb_act[0]) mask_d = 6'b000001;
        else if (enb_act[5]) begin
          commit = &mask_q[4:0];
          mask_d = '0;
        end else mask_d = mask_q | enb_act;
      end else begin
        err_enb_d = 1'b1;
        mask_d    = '0;
      end
    end

    tv_c     = (shadow_d[0] <= 4'd9) && (shadow_d[1] <= 4'd9) &&
               (shadow_d[2] <= 4'd9) && (shadow_d[3] <= 4'd9);
    min_full = 8'(shadow_d[3]) * 8'd10 + 8'(shadow_d[2]);
    sec_full = 8'(shadow_d[1]) * 8'd10 + 8'(shadow_d[0]);

    if (commit) begin
      digits_d = shadow_d;
      dp_d     = sdp_d;
      blank_d  = sblank_d;
      tv_d     = tv_c;
      min_d    = tv_c ? min_full[5:0] : 6'd0;
      sec_d    = tv_c ? sec_full[5:0] : 6'd0;
      frame_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      shadow_q  <= '0;
      sdp_q     <= '0;
      sblank_q  <= '0;
      mask_q    <= '0;
      digits_q  <= '1;
      dp_q      <= '0;
      blank_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      tv_q      <= 1'b0;
      frame_q   <= 1'b0;
      err_seg_q <= 1'b0;
      err_enb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      sdp_q     <= sdp_d;
      sblank_q  <= sblank_d;
      mask_q    <= mask_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      tv_q      <= tv_d;
      frame_q   <= frame_d;
      err_seg_q <= err_seg_d;
      err_enb_q <= err_enb_d;
    end
  end

  assign o_digits    = digits_q;
  assign o_dp        = dp_q;
  assign o_blank     = blank_q;
  assign o_min       = min_q;
  assign o_sec       = sec_q;
  assign o_time_vld  = tv_q;
  assign o_frame_vld = frame_q;
  assign o_err_seg   = err_seg_q;
  assign o_err_enb   = err_enb_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed scans of the 7-segment bus; expected frames are queued as scans are
// issued and a monitor checks each committed frame against the queue head.
module tb_seg_scan_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic        i_err_clr;
  logic [23:0] o_digits;
  logic [5:0]  o_dp, o_blank, o_min, o_sec;
  logic        o_time_vld, o_frame_vld, o_err_seg, o_err_enb;

  always #10 clk = ~clk;

  seg_scan_rx #(.SETTLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp),
    .i_seg_enb(i_seg_enb), .i_err_clr(i_err_clr), .o_digits(o_digits),
    .o_dp(o_dp), .o_blank(o_blank), .o_min(o_min), .o_sec(o_sec),
    .o_time_vld(o_time_vld), .o_frame_vld(o_frame_vld),
    .o_err_seg(o_err_seg), .o_err_enb(o_err_enb)
  );

  typedef struct packed {
    logic [23:0] dig;
    logic [5:0]  dp;
    logic [5:0]  bl;
    logic [5:0]  mn;
    logic [5:0]  sc;
    logic        tv;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0][6:0] P1234 = {7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h33};
  localparam logic [5:0][6:0] P123E = {7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h01};
  localparam logic [5:0][6:0] P5959 = {7'h00, 7'h00, 7'h5B, 7'h73, 7'h5B, 7'h73};
  localparam logic [5:0][6:0] P6000 = {7'h00, 7'h00, 7'h5F, 7'h7E, 7'h7E, 7'h7E};
  localparam logic [5:0][6:0] P8607 = {7'h7F, 7'h5F, 7'h7E, 7'h70, 7'h7E, 7'h5B};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_frame_vld) begin
      frame_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got digits %h, expected no frame", o_digits);
      end else begin
        e = exp_q.pop_front();
        chk("frame_digits", o_digits, e.dig);
        chk("frame_dp", o_dp, e.dp);
        chk("frame_blank", o_blank, e.bl);
        chk("frame_min", o_min, e.mn);
        chk("frame_sec", o_sec, e.sc);
        chk("frame_time_vld", o_time_vld, e.tv);
      end
    end
  end

  function automatic logic [5:0] en_of(input int k);
    en_of = ~(6'd1 << k);
  endfunction

  // Entered and left at posedge+1.
  task automatic hold(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [5:0][6:0] p, input logic [5:0] d, input int n);
    for (int k = 0; k < 6; k++) hold(en_of(k), p[k], d[k], n);
    hold(6'h3F, 7'h00, 1'b0, 8);
  endtask

  task automatic expect_frame(input logic [23:0] dg, input logic [5:0] dp, input logic [5:0] bl,
                              input logic [5:0] mn, input logic [5:0] sc, input logic tv);
    frame_t f;
    f.dig = dg; f.dp = dp; f.bl = bl; f.mn = mn; f.sc = sc; f.tv = tv;
    exp_q.push_back(f);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_digits"}, o_digits, 24'hFFFFFF);
    chk({tag, "_others"}, {o_dp, o_blank, o_min, o_sec, o_time_vld, o_frame_vld,
                           o_err_seg, o_err_enb}, 28'd0);
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    @(posedge clk);
    #1;
    i_err_clr = 1'b0;
  endtask

  initial begin
    i_seg = '0; i_seg_dp = 1'b0; i_seg_enb = 6'h3F; i_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    hold(6'h3F, 7'h00, 1'b0, 5);

    // 12:34 at full dwell, colon dp on digit 2
    expect_frame(24'hFF1234, 6'b000100, 6'b110000, 6'd12, 6'd34, 1'b1);
    scan(P1234, 6'b000100, 5000);
    chk("clean_err_seg", o_err_seg, 1'b0);
    chk("clean_err_enb", o_err_enb, 1'b0);

    // 2-cycle 7F glitch on digit 2 must be ignored
    expect_frame(24'hFF1234, 6'b000100, 6'b110000, 6'd12, 6'd34, 1'b1);
    hold(en_of(0), 7'h33, 1'b0, 20);
    hold(en_of(1), 7'h79, 1'b0, 20);
    hold(en_of(2), 7'h7F, 1'b1, 2);
    hold(en_of(2), 7'h6D, 1'b1, 20);
    hold(en_of(3), 7'h30, 1'b0, 20);
    hold(en_of(4), 7'h00, 1'b0, 20);
    hold(en_of(5), 7'h00, 1'b0, 20);
    hold(6'h3F, 7'h00, 1'b0, 8);
    chk("glitch_digit2", o_digits[11:8], 4'd2);
    chk("glitch_err_seg", o_err_seg, 1'b0);

    // undecodable pattern on digit 0
    expect_frame(24'hFF123E, 6'b000000, 6'b110000, 6'd0, 6'd0, 1'b0);
    scan(P123E, 6'b000000, 20);
    chk("bad_seg_err", o_err_seg, 1'b1);
    pulse_clr();
    chk("bad_seg_cleared", o_err_seg, 1'b0);

    // two enables low mid-scan: error, no commit
    hold(en_of(0), 7'h33, 1'b0, 20);
    hold(en_of(1), 7'h79, 1'b0, 20);
    hold(6'b111100, 7'h6D, 1'b0, 10);
    for (int k = 2; k < 6; k++) hold(en_of(k), P1234[k], 1'b0, 20);
    hold(6'h3F, 7'h00, 1'b0, 8);
    chk("multi_err_enb", o_err_enb, 1'b1);
    chk("multi_no_commit", o_digits, 24'hFF123E);
    expect_frame(24'hFF1234, 6'b000000, 6'b110000, 6'd12, 6'd34, 1'b1);
    scan(P1234, 6'b000000, 20);
    pulse_clr();
    chk("multi_err_cleared", o_err_enb, 1'b0);

    // digit 3 skipped: no commit
    for (int k = 0; k < 6; k++) if (k != 3) hold(en_of(k), P5959[k], 1'b0, 20);
    hold(6'h3F, 7'h00, 1'b0, 8);
    chk("skip_unchanged", o_digits, 24'hFF1234);
    expect_frame(24'hFF5959, 6'b000000, 6'b110000, 6'd59, 6'd59, 1'b1);
    scan(P5959, 6'b000000, 20);

    // minutes above 59 pass through
    expect_frame(24'hFF6000, 6'b000000, 6'b110000, 6'd60, 6'd0, 1'b1);
    scan(P6000, 6'b000000, 20);

    // reset after digit 3 of a scan that also raised err_seg
    hold(en_of(0), 7'h01, 1'b0, 20);
    hold(en_of(1), 7'h7E, 1'b0, 20);
    hold(en_of(2), 7'h70, 1'b0, 20);
    hold(en_of(3), 7'h7E, 1'b0, 20);
    chk("pre_reset_err_seg", o_err_seg, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset("async");
    hold(6'h3F, 7'h00, 1'b0, 3);
    rst_n = 1'b1;
    hold(6'h3F, 7'h00, 1'b0, 5);
    expect_frame(24'h860705, 6'b000000, 6'b000000, 6'd7, 6'd5, 1'b1);
    scan(P8607, 6'b000000, 20);
    chk("post_reset_err_seg", o_err_seg, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("frames_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
